// File: rtl/score_bcd_counter.sv
// Snake score keeper: saturating score counter, session high score, and a sequential
// double-dabble converter that feeds packed BCD of the selected score to the display.
module score_bcd_counter #(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999,
    parameter int POINTS    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               add_pulse,
    input  logic               show_high,
    output logic [SCORE_W-1:0] score_bin,
    output logic [SCORE_W-1:0] hi_bin,
    output logic [15:0]        bcd_out,
    output logic               bcd_valid,
    output logic               busy
);

    localparam int SH_W   = SCORE_W + 16;
    localparam int ITER_W = $clog2(SCORE_W + 1);

    localparam logic [SCORE_W:0]    MAX_EXT    = (SCORE_W + 1)'(MAX_SCORE);
    localparam logic [SCORE_W:0]    POINTS_EXT = (SCORE_W + 1)'(POINTS);
    localparam logic [ITER_W-1:0]   LAST_ITER  = ITER_W'(SCORE_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  src;
    logic [SCORE_W-1:0]  last_src;
    logic                src_changed;
    logic [SH_W-1:0]     shreg;
    logic [SH_W-1:0]     bcd_adj;
    logic [ITER_W-1:0]   iter;

    // One extra bit on the sum so saturation is detected before any wrap.
    assign score_sum   = {1'b0, score_bin} + POINTS_EXT;
    assign src         = show_high ? hi_bin : score_bin;
    assign src_changed = (src != last_src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_bin <= '0;
        end else if (clear) begin
            score_bin <= '0;
        end else if (add_pulse) begin
            score_bin <= (score_sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_bin <= '0;
        end else if (score_bin > hi_bin) begin
            hi_bin <= score_bin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (src_changed) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (iter == LAST_ITER) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Add-3 correction on every BCD digit before the shift keeps each digit in 0..9.
    always_comb begin
        bcd_adj = shreg;
        for (int k = 0; k < 4; k++) begin
            if (shreg[SCORE_W + 4*k +: 4] >= 4'd5) begin
                bcd_adj[SCORE_W + 4*k +: 4] = shreg[SCORE_W + 4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            iter      <= '0;
            last_src  <= '0;
            bcd_out   <= 16'h0000;
            bcd_valid <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (src_changed) begin
                        bcd_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    shreg    <= {16'h0000, src};
                    last_src <= src;
                    iter     <= '0;
                end
                SHIFT: begin
                    shreg <= {bcd_adj[SH_W-2:0], 1'b0};
                    iter  <= iter + ITER_W'(1);
                end
                DONE: begin
                    bcd_out   <= shreg[SH_W-1 -: 16];
                    bcd_valid <= !src_changed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench for score_bcd_counter: vector table, directed corner sequences
// and a randomized run checked against an arithmetic score/high-score/BCD model.
module tb_score_bcd_counter;

    localparam int SCORE_W   = 14;
    localparam int MAX_SCORE = 9999;
    localparam int POINTS    = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic               add_pulse;
    logic               show_high;
    logic [SCORE_W-1:0] score_bin;
    logic [SCORE_W-1:0] hi_bin;
    logic [15:0]        bcd_out;
    logic               bcd_valid;
    logic               busy;

    int checks = 0;
    int passes = 0;
    int m_score = 0;
    int m_hi = 0;

    typedef struct {
        logic c;
        logic a;
        logic s;
        int   exp_score;
        int   exp_hi;
    } vec_t;

    vec_t vecs[10];

    score_bcd_counter #(
        .SCORE_W  (SCORE_W),
        .MAX_SCORE(MAX_SCORE),
        .POINTS   (POINTS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .add_pulse(add_pulse),
        .show_high(show_high),
        .score_bin(score_bin),
        .hi_bin   (hi_bin),
        .bcd_out  (bcd_out),
        .bcd_valid(bcd_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    // Drive inputs on the falling edge, advance the model on the rising edge, sample 1 time unit later.
    task automatic applyStimulus(logic c, logic a, logic s);
        int old;
        @(negedge clk);
        clear     = c;
        add_pulse = a;
        show_high = s;
        @(posedge clk);
        if (rst_n) begin
            old = m_score;
            if (old > m_hi) m_hi = old;
            if (c) m_score = 0;
            else if (a) m_score = (m_score + POINTS > MAX_SCORE) ? MAX_SCORE : m_score + POINTS;
        end
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n     = 1'b0;
        clear     = 1'b0;
        add_pulse = 1'b0;
        show_high = 1'b0;
        m_score   = 0;
        m_hi      = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitSettled(string name);
        int n;
        logic s;
        s = show_high;
        applyStimulus(1'b0, 1'b0, s);
        applyStimulus(1'b0, 1'b0, s);
        n = 0;
        while (!(bcd_valid && !busy) && n < 60) begin
            applyStimulus(1'b0, 1'b0, s);
            n++;
        end
        checkOutput({name, " valid"}, 32'(bcd_valid), 32'd1);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        checkOutput({name, " bcd"}, 32'(bcd_out), 32'(to_bcd(s ? m_hi : m_score)));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic c, a, s, digits_ok;

        rst_n = 1'b1; clear = 1'b0; add_pulse = 1'b0; show_high = 1'b0;

        // T1 reset, checked while still held and after release
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("T1 score", 32'(score_bin), 32'd0);
        checkOutput("T1 hi", 32'(hi_bin), 32'd0);
        checkOutput("T1 bcd", 32'(bcd_out), 32'h0000);
        checkOutput("T1 valid", 32'(bcd_valid), 32'd1);
        checkOutput("T1 busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Vector table: score/high-score per step from reset
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2, 1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 2, 2};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 0, 2};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1, 2};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 0, 2};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1, 2};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 2, 2};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 3, 2};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 3, 3};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].c, vecs[i].a, vecs[i].s);
            checkOutput($sformatf("vec%0d score", i), 32'(score_bin), 32'(vecs[i].exp_score));
            checkOutput($sformatf("vec%0d hi", i), 32'(hi_bin), 32'(vecs[i].exp_hi));
        end
        waitSettled("vec");
        checkOutput("vec bcd const", 32'(bcd_out), 32'h0003);

        // T2 exact conversion latency for one add
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("T2 score", 32'(score_bin), 32'd1);
        checkOutput("T2 busy before", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("T2 busy rises", 32'(busy), 32'd1);
        for (int i = 2; i <= 16; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("T2 bcd held", 32'(bcd_out), 32'h0000);
        checkOutput("T2 valid low", 32'(bcd_valid), 32'd0);
        checkOutput("T2 busy in done", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("T2 bcd", 32'(bcd_out), 32'h0001);
        checkOutput("T2 valid", 32'(bcd_valid), 32'd1);
        checkOutput("T2 busy after", 32'(busy), 32'd0);

        // T3 burst of 1234 adds
        applyReset();
        for (int i = 0; i < 1234; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("T3 score", 32'(score_bin), 32'd1234);
        waitSettled("T3");
        checkOutput("T3 bcd const", 32'(bcd_out), 32'h1234);

        // T4 climb to 9998 then saturate
        for (int i = 0; i < 8764; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("T4 preload", 32'(score_bin), 32'd9998);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("T4 score", 32'(score_bin), 32'd9999);
        waitSettled("T4");
        checkOutput("T4 bcd const", 32'(bcd_out), 32'h9999);
        checkOutput("T4 hi", 32'(hi_bin), 32'd9999);

        // T5 clear beats add, high score kept
        applyReset();
        for (int i = 0; i < 42; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("T5 score", 32'(score_bin), 32'd0);
        checkOutput("T5 hi", 32'(hi_bin), 32'd42);
        waitSettled("T5 score");
        checkOutput("T5 bcd const", 32'(bcd_out), 32'h0000);
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitSettled("T5 high");
        checkOutput("T5 high const", 32'(bcd_out), 32'h0042);

        // T6 async reset during SHIFT iteration 7 of a 0 -> 567 conversion
        applyReset();
        for (int i = 0; i < 567; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitSettled("T6 pre");
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("T6 busy mid", 32'(busy), 32'd1);
        checkOutput("T6 bcd held", 32'(bcd_out), 32'h0000);
        checkOutput("T6 valid mid", 32'(bcd_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("T6 score", 32'(score_bin), 32'd0);
        checkOutput("T6 hi", 32'(hi_bin), 32'd0);
        checkOutput("T6 bcd", 32'(bcd_out), 32'h0000);
        checkOutput("T6 valid", 32'(bcd_valid), 32'd1);
        checkOutput("T6 busy", 32'(busy), 32'd0);
        @(negedge clk);
        m_score = 0; m_hi = 0;
        clear = 1'b0; add_pulse = 1'b0; show_high = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("T6 idle busy", 32'(busy), 32'd0);
        checkOutput("T6 idle valid", 32'(bcd_valid), 32'd1);

        // Randomized run against the arithmetic model
        applyReset();
        s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 49) == 0);
            a = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) s = !s;
            applyStimulus(c, a, s);
            checkOutput("rand score", 32'(score_bin), 32'(m_score));
            checkOutput("rand hi", 32'(hi_bin), 32'(m_hi));
            digits_ok = (bcd_out[3:0] <= 4'd9) && (bcd_out[7:4] <= 4'd9) &&
                        (bcd_out[11:8] <= 4'd9) && (bcd_out[15:12] <= 4'd9);
            checkOutput("rand digits", 32'(digits_ok), 32'd1);
            if (i % 250 == 249) waitSettled("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
